// File: rtl/dps_codec_07.sv
// Crosstalk-avoidance codec for a 7-line TSV bundle: 0..41 <-> 7-bit words with no 010/101 window.
// Registered encoder on the transmit side, combinational decoder on the receive side.
module dps_codec_07 #(
    localparam int DBLEN07 = 6,
    localparam int TSVW    = 7
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic [DBLEN07-1:0] datain,
    output logic [TSVW-1:0]    tsv,
    input  logic [TSVW-1:0]    tsv_rx,
    output logic [DBLEN07-1:0] dataout
);

    localparam logic [DBLEN07-1:0] MAX_DATA = 6'd41;
    localparam logic [DBLEN07-1:0] ERR_MARK = 6'd63;
    localparam logic [4:0]         NO_RANK  = 5'd31;

    // The upper 21 codewords are the bitwise inverses of the lower 21 in reverse
    // order, so both directions only need the MSB-clear half of the table.
    function automatic logic [TSVW-1:0] enc_half(input logic [4:0] d);
        logic [TSVW-1:0] w;
        case (d)
            5'd0:    w = 7'b0000000;
            5'd1:    w = 7'b0000001;
            5'd2:    w = 7'b0000011;
            5'd3:    w = 7'b0000110;
            5'd4:    w = 7'b0000111;
            5'd5:    w = 7'b0001100;
            5'd6:    w = 7'b0001110;
            5'd7:    w = 7'b0001111;
            5'd8:    w = 7'b0011000;
            5'd9:    w = 7'b0011001;
            5'd10:   w = 7'b0011100;
            5'd11:   w = 7'b0011110;
            5'd12:   w = 7'b0011111;
            5'd13:   w = 7'b0110000;
            5'd14:   w = 7'b0110001;
            5'd15:   w = 7'b0110011;
            5'd16:   w = 7'b0111000;
            5'd17:   w = 7'b0111001;
            5'd18:   w = 7'b0111100;
            5'd19:   w = 7'b0111110;
            5'd20:   w = 7'b0111111;
            default: w = 7'b0000000;
        endcase
        return w;
    endfunction

    // Returns NO_RANK for any word that is not a valid MSB-clear codeword.
    function automatic logic [4:0] rank_half(input logic [TSVW-1:0] w);
        logic [4:0] r;
        case (w)
            7'b0000000: r = 5'd0;
            7'b0000001: r = 5'd1;
            7'b0000011: r = 5'd2;
            7'b0000110: r = 5'd3;
            7'b0000111: r = 5'd4;
            7'b0001100: r = 5'd5;
            7'b0001110: r = 5'd6;
            7'b0001111: r = 5'd7;
            7'b0011000: r = 5'd8;
            7'b0011001: r = 5'd9;
            7'b0011100: r = 5'd10;
            7'b0011110: r = 5'd11;
            7'b0011111: r = 5'd12;
            7'b0110000: r = 5'd13;
            7'b0110001: r = 5'd14;
            7'b0110011: r = 5'd15;
            7'b0111000: r = 5'd16;
            7'b0111001: r = 5'd17;
            7'b0111100: r = 5'd18;
            7'b0111110: r = 5'd19;
            7'b0111111: r = 5'd20;
            default:    r = NO_RANK;
        endcase
        return r;
    endfunction

    logic [TSVW-1:0]    tsv_q;
    logic [TSVW-1:0]    tsv_d;
    logic [DBLEN07-1:0] mirror_data;

    always_comb begin
        tsv_d       = tsv_q;
        mirror_data = MAX_DATA - datain;
        if (datain <= MAX_DATA) begin
            if (datain[5] == 1'b0 && datain[4:0] <= 5'd20) begin
                tsv_d = enc_half(datain[4:0]);
            end else begin
                tsv_d = ~enc_half(mirror_data[4:0]);
            end
        end
    end

    // Out-of-range data leaves the previous codeword on the bundle.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tsv_q <= '0;
        end else begin
            tsv_q <= tsv_d;
        end
    end

    assign tsv = tsv_q;

    logic [TSVW-1:0] rx_low;
    logic [4:0]      rx_rank;

    always_comb begin
        rx_low  = tsv_rx[TSVW-1] ? ~tsv_rx : tsv_rx;
        rx_rank = rank_half(rx_low);
        dataout = ERR_MARK;
        if (rx_rank != NO_RANK) begin
            if (tsv_rx[TSVW-1]) begin
                dataout = MAX_DATA - {1'b0, rx_rank};
            end else begin
                dataout = {1'b0, rx_rank};
            end
        end
    end

endmodule

// File: tb/tb_dps_codec_07.sv
// Bench for dps_codec_07: reference code set built by enumerating all 7-bit words,
// anchor table, scoreboarded encode/loopback, exhaustive decode, hold and soak.
module tb_dps_codec_07;

    logic       clock;
    logic       rst_n;
    logic [5:0] datain;
    logic [6:0] tsv;
    logic [6:0] tsv_rx;
    logic [5:0] dataout;
    logic       loop_en;
    logic [6:0] rx_drv;

    assign tsv_rx = loop_en ? tsv : rx_drv;

    dps_codec_07 dut (
        .clock   (clock),
        .rst_n   (rst_n),
        .datain  (datain),
        .tsv     (tsv),
        .tsv_rx  (tsv_rx),
        .dataout (dataout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] code_m [0:41];
    logic [5:0] rank_m [0:127];
    logic [6:0] exp_q [$];
    logic [5:0] exp_d_q [$];
    logic [6:0] hold_tsv;
    logic [5:0] hold_data;

    typedef struct {
        logic [5:0] din;
        logic [6:0] code;
    } vec_t;
    vec_t anchors [0:7];

    function automatic bit no_isolated(input logic [6:0] w);
        for (int j = 0; j <= 4; j++) begin
            if (w[j +: 3] == 3'b010 || w[j +: 3] == 3'b101) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end
    endtask

    // Drive one value at the falling edge, then score the word registered at the next rising edge.
    task automatic drive(input logic [5:0] din, input string name);
        logic [6:0] et;
        logic [5:0] ed;
        @(negedge clock);
        datain = din;
        if (din <= 6'd41) begin
            hold_tsv  = code_m[din];
            hold_data = din;
        end
        exp_q.push_back(hold_tsv);
        exp_d_q.push_back(hold_data);
        @(posedge clock);
        #1;
        et = exp_q.pop_front();
        ed = exp_d_q.pop_front();
        check({name, "_tsv"}, int'(tsv), int'(et));
        check({name, "_loop"}, int'(dataout), int'(ed));
    endtask

    initial begin
        int n;
        logic [6:0] prev;
        n = 0;
        for (int w = 0; w < 128; w++) begin
            if (no_isolated(7'(w))) begin
                code_m[n] = 7'(w);
                rank_m[w] = 6'(n);
                n++;
            end else begin
                rank_m[w] = 6'd63;
            end
        end
        check("code_set_size", n, 42);

        anchors[0] = '{6'd0,  7'b0000000};
        anchors[1] = '{6'd1,  7'b0000001};
        anchors[2] = '{6'd2,  7'b0000011};
        anchors[3] = '{6'd3,  7'b0000110};
        anchors[4] = '{6'd5,  7'b0001100};
        anchors[5] = '{6'd38, 7'b1111001};
        anchors[6] = '{6'd39, 7'b1111100};
        anchors[7] = '{6'd41, 7'b1111111};

        // Reset held with datain at the top code: bundle must stay all-zero.
        loop_en   = 1'b1;
        rx_drv    = '0;
        rst_n     = 1'b0;
        datain    = 6'd41;
        hold_tsv  = '0;
        hold_data = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("reset_tsv", int'(tsv), 0);
            check("reset_loop", int'(dataout), 0);
        end
        @(negedge clock);
        rst_n = 1'b1;
        drive(6'd41, "post_reset");
        check("post_reset_literal", int'(tsv), 7'h7f);

        for (int i = 0; i < 8; i++) begin
            drive(anchors[i].din, "anchor");
            check("anchor_literal", int'(tsv), int'(anchors[i].code));
        end

        prev = '0;
        for (int d = 0; d < 42; d++) begin
            drive(6'(d), "sweep");
            check("sweep_no_010_101", int'(no_isolated(tsv)), 1);
            if (d > 0) check("sweep_ascending", int'(tsv > prev), 1);
            prev = tsv;
        end

        drive(6'd7, "hold_seed");
        check("hold_seed_literal", int'(tsv), 7'b0001111);
        drive(6'd42, "hold_42");
        check("hold_42_literal", int'(tsv), 7'b0001111);
        drive(6'd63, "hold_63");
        check("hold_63_literal", int'(tsv), 7'b0001111);

        // Asynchronous reset asserted mid-cycle, then released with new data pending.
        drive(6'd30, "pre_mid_reset");
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_async", int'(tsv), 0);
        @(posedge clock);
        #1;
        check("mid_reset_held", int'(tsv), 0);
        hold_tsv  = '0;
        hold_data = '0;
        @(negedge clock);
        rst_n = 1'b1;
        drive(6'd5, "after_mid_reset");

        loop_en = 1'b0;
        for (int w = 0; w < 128; w++) begin
            rx_drv = 7'(w);
            #1;
            check("decode", int'(dataout), int'(rank_m[w]));
        end
        rx_drv = 7'b0000010;
        #1;
        check("decode_0000010", int'(dataout), 63);
        rx_drv = 7'b1010101;
        #1;
        check("decode_1010101", int'(dataout), 63);
        rx_drv = 7'b0011001;
        #1;
        check("decode_0011001", int'(dataout), 9);
        loop_en = 1'b1;

        for (int i = 0; i < 10000; i++) begin
            drive(6'($urandom_range(0, 41)), "soak");
            if (no_isolated(tsv) == 1'b0) check("soak_no_010_101", 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
